// File: rtl/air_hockey_pkg.sv
// air_hockey_pkg: shared playfield geometry, puck FSM states and the
// velocity type used by the puck physics engine and its mallet checker.
// Holds small helpers for sign extension, magnitude and friction decay
// of the 5-bit signed velocity.
package air_hockey_pkg;

    // Playfield geometry, px
    localparam int X_MIN     = 44;
    localparam int X_MAX     = 979;
    localparam int Y_MIN     = 40;
    localparam int Y_MAX     = 727;
    localparam int GOAL_Y_LO = 302;
    localparam int GOAL_Y_HI = 422;
    localparam int X_START   = 487;
    localparam int Y_START   = 362;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLIDE = 3'd1,
        MOVE    = 3'd2,
        BOUND   = 3'd3,
        GOAL    = 3'd4
    } state_t;

    // Velocity in px/frame, two's complement
    typedef logic signed [4:0] vel_t;

    function automatic logic [11:0] vel_sext(input vel_t v);
        return {{7{v[4]}}, v};
    endfunction

    function automatic vel_t vel_abs(input vel_t v);
        return v[4] ? -v : v;
    endfunction

    // One friction step: move one unit toward zero
    function automatic vel_t vel_decay(input vel_t v);
        if (v > 5'sd0)
            return v - 5'sd1;
        else if (v < 5'sd0)
            return v + 5'sd1;
        else
            return v;
    endfunction

endpackage

// File: rtl/mallet_hit.sv
// mallet_hit: combinational puck/mallet contact test.
// Ports:
//   ball_x/ball_y     puck centre
//   mallet_x/mallet_y mallet centre
//   hit               centres closer than RADIUS_SUM (strict)
//   vx_new/vy_new     rebound velocity: contact vector >>> HIT_SHIFT,
//                     clamped to +/-VMAX, never both zero
module mallet_hit
    import air_hockey_pkg::*;
#(
    parameter int RADIUS_SUM = 30,
    parameter int VMAX       = 7,
    parameter int HIT_SHIFT  = 2
) (
    input  logic [11:0] ball_x,
    input  logic [11:0] ball_y,
    input  logic [11:0] mallet_x,
    input  logic [11:0] mallet_y,
    output logic        hit,
    output vel_t        vx_new,
    output vel_t        vy_new
);

    localparam logic [26:0]        HIT_D2 = 27'(RADIUS_SUM * RADIUS_SUM);
    localparam logic signed [12:0] VLIM   = 13'(VMAX);
    localparam vel_t               VMAX_V = 5'(VMAX);

    logic signed [12:0] dx, dy, dx_sh, dy_sh;
    logic signed [26:0] dxw, dyw;
    logic        [26:0] d2;

    assign dx  = $signed({1'b0, ball_x}) - $signed({1'b0, mallet_x});
    assign dy  = $signed({1'b0, ball_y}) - $signed({1'b0, mallet_y});
    assign dxw = {{14{dx[12]}}, dx};
    assign dyw = {{14{dy[12]}}, dy};
    assign d2  = dxw * dxw + dyw * dyw;
    assign hit = (d2 < HIT_D2);

    assign dx_sh = dx >>> HIT_SHIFT;
    assign dy_sh = dy >>> HIT_SHIFT;

    function automatic vel_t sat(input logic signed [12:0] v);
        if (v > VLIM)
            return VMAX_V;
        else if (v < -VLIM)
            return -VMAX_V;
        else
            return v[4:0];
    endfunction

    always_comb begin
        vx_new = sat(dx_sh);
        vy_new = sat(dy_sh);
        // A grazing contact near the centre would shift to zero; still push the puck away
        if (vx_new == 5'sd0 && vy_new == 5'sd0)
            vx_new = dx[12] ? -5'sd1 : 5'sd1;
    end

endmodule

// File: rtl/puck_physics.sv
// puck_physics: per-frame puck motion engine for the air-hockey table.
// Each honoured frame_tick runs IDLE -> COLLIDE -> MOVE -> BOUND, and the
// new position appears on the outputs 4 cycles after the tick.
// Ports:
//   clk_in, rst          clock, synchronous active-high reset
//   frame_tick           one-cycle pulse per video frame
//   xpos/ypos_player_N   mallet centres (mallet 1 has priority)
//   xpos/ypos_ball       registered puck centre
//   goal_p1/goal_p2      one-cycle score pulses
//   score_p1/score_p2    saturating goal counters
//   busy                 FSM not in IDLE
module puck_physics
    import air_hockey_pkg::*;
#(
    parameter int RADIUS_BALL     = 10,
    parameter int PLAYERS_RADIUS  = 20,
    parameter int VMAX            = 7,
    parameter int HIT_SHIFT       = 2,
    parameter int FRICTION_FRAMES = 16,  // up to 256
    parameter int SERVE_FRAMES    = 60   // up to 256
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [11:0] xpos_player_1,
    input  logic [11:0] ypos_player_1,
    input  logic [11:0] xpos_player_2,
    input  logic [11:0] ypos_player_2,
    output logic [11:0] xpos_ball,
    output logic [11:0] ypos_ball,
    output logic        goal_p1,
    output logic        goal_p2,
    output logic [3:0]  score_p1,
    output logic [3:0]  score_p2,
    output logic        busy
);

    // Contact limits on the puck centre (edge touches or crosses the wall)
    localparam logic [11:0] LEFT_LIM    = 12'(X_MIN + RADIUS_BALL);
    localparam logic [11:0] RIGHT_LIM   = 12'(X_MAX - RADIUS_BALL);
    localparam logic [11:0] TOP_LIM     = 12'(Y_MIN + RADIUS_BALL);
    localparam logic [11:0] BOT_LIM     = 12'(Y_MAX - RADIUS_BALL);
    localparam logic [11:0] GOAL_LO     = 12'(GOAL_Y_LO);
    localparam logic [11:0] GOAL_HI     = 12'(GOAL_Y_HI);
    localparam logic [11:0] X_SERVE     = 12'(X_START);
    localparam logic [11:0] Y_SERVE     = 12'(Y_START);
    localparam logic [7:0]  FRIC_LAST   = 8'(FRICTION_FRAMES - 1);
    localparam logic [7:0]  SERVE_LAST  = 8'(SERVE_FRAMES - 1);

    state_t      state;
    vel_t        vx, vy;
    logic [7:0]  fric_cnt, serve_cnt;
    logic        fric_due;

    logic        hit1, hit2;
    vel_t        vx1, vy1, vx2, vy2;
    logic        in_mouth, at_left, at_right, at_top, at_bot;

    mallet_hit #(
        .RADIUS_SUM (RADIUS_BALL + PLAYERS_RADIUS),
        .VMAX       (VMAX),
        .HIT_SHIFT  (HIT_SHIFT)
    ) u_hit1 (
        .ball_x   (xpos_ball),
        .ball_y   (ypos_ball),
        .mallet_x (xpos_player_1),
        .mallet_y (ypos_player_1),
        .hit      (hit1),
        .vx_new   (vx1),
        .vy_new   (vy1)
    );

    mallet_hit #(
        .RADIUS_SUM (RADIUS_BALL + PLAYERS_RADIUS),
        .VMAX       (VMAX),
        .HIT_SHIFT  (HIT_SHIFT)
    ) u_hit2 (
        .ball_x   (xpos_ball),
        .ball_y   (ypos_ball),
        .mallet_x (xpos_player_2),
        .mallet_y (ypos_player_2),
        .hit      (hit2),
        .vx_new   (vx2),
        .vy_new   (vy2)
    );

    always_comb begin
        in_mouth = (ypos_ball >= GOAL_LO) && (ypos_ball <= GOAL_HI);
        at_left  = (xpos_ball <= LEFT_LIM);
        at_right = (xpos_ball >= RIGHT_LIM);
        at_top   = (ypos_ball <= TOP_LIM);
        at_bot   = (ypos_ball >= BOT_LIM);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= IDLE;
            xpos_ball <= X_SERVE;
            ypos_ball <= Y_SERVE;
            vx        <= '0;
            vy        <= '0;
            goal_p1   <= 1'b0;
            goal_p2   <= 1'b0;
            score_p1  <= '0;
            score_p2  <= '0;
            fric_cnt  <= '0;
            serve_cnt <= '0;
            fric_due  <= 1'b0;
        end else begin
            goal_p1 <= 1'b0;
            goal_p2 <= 1'b0;
            case (state)
                IDLE: if (frame_tick) begin
                    state <= COLLIDE;
                    // Friction is counted on the tick; the step lands after
                    // this frame's move so the frame still uses the old speed.
                    if (fric_cnt == FRIC_LAST) begin
                        fric_cnt <= '0;
                        fric_due <= 1'b1;
                    end else begin
                        fric_cnt <= fric_cnt + 8'd1;
                        fric_due <= 1'b0;
                    end
                end
                COLLIDE: begin
                    if (hit1) begin
                        vx <= vx1;
                        vy <= vy1;
                    end else if (hit2) begin
                        vx <= vx2;
                        vy <= vy2;
                    end
                    state <= MOVE;
                end
                MOVE: begin
                    xpos_ball <= xpos_ball + vel_sext(vx);
                    ypos_ball <= ypos_ball + vel_sext(vy);
                    if (fric_due) begin
                        vx <= vel_decay(vx);
                        vy <= vel_decay(vy);
                    end
                    state <= BOUND;
                end
                BOUND: begin
                    if (at_left && in_mouth) begin
                        goal_p2   <= 1'b1;
                        score_p2  <= (score_p2 == 4'd15) ? score_p2 : score_p2 + 4'd1;
                        vx        <= '0;
                        vy        <= '0;
                        serve_cnt <= '0;
                        state     <= GOAL;
                    end else if (at_right && in_mouth) begin
                        goal_p1   <= 1'b1;
                        score_p1  <= (score_p1 == 4'd15) ? score_p1 : score_p1 + 4'd1;
                        vx        <= '0;
                        vy        <= '0;
                        serve_cnt <= '0;
                        state     <= GOAL;
                    end else begin
                        // Clamp one pixel inside so the next frame does not re-trigger
                        if (at_left) begin
                            xpos_ball <= LEFT_LIM + 12'd1;
                            vx        <= vel_abs(vx);
                        end else if (at_right) begin
                            xpos_ball <= RIGHT_LIM - 12'd1;
                            vx        <= -vel_abs(vx);
                        end
                        if (at_top) begin
                            ypos_ball <= TOP_LIM + 12'd1;
                            vy        <= vel_abs(vy);
                        end else if (at_bot) begin
                            ypos_ball <= BOT_LIM - 12'd1;
                            vy        <= -vel_abs(vy);
                        end
                        state <= IDLE;
                    end
                end
                GOAL: if (frame_tick) begin
                    if (serve_cnt == SERVE_LAST) begin
                        xpos_ball <= X_SERVE;
                        ypos_ball <= Y_SERVE;
                        fric_cnt  <= '0;
                        serve_cnt <= '0;
                        state     <= IDLE;
                    end else begin
                        serve_cnt <= serve_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_puck_physics.sv
// tb_puck_physics: directed and randomized frames against a per-frame
// behavioural model of the puck (integer arithmetic, whole-frame rules).
module tb_puck_physics;

    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic [11:0] xp1 = '0, yp1 = '0, xp2 = '0, yp2 = '0;
    logic [11:0] xpos_ball, ypos_ball;
    logic        goal_p1, goal_p2, busy;
    logic [3:0]  score_p1, score_p2;

    puck_physics dut (
        .clk_in        (clk_in),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .xpos_player_1 (xp1),
        .ypos_player_1 (yp1),
        .xpos_player_2 (xp2),
        .ypos_player_2 (yp2),
        .xpos_ball     (xpos_ball),
        .ypos_ball     (ypos_ball),
        .goal_p1       (goal_p1),
        .goal_p2       (goal_p2),
        .score_p1      (score_p1),
        .score_p2      (score_p2),
        .busy          (busy)
    );

    always #5 clk_in = ~clk_in;

    int n_pass = 0;
    int n_total = 0;

    // Reference model state
    int mx, my, mvx, mvy, fcnt, serve, ms1, ms2;
    bit m_goal, eg1, eg2;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic int clamp7(input int v);
        return (v > 7) ? 7 : ((v < -7) ? -7 : v);
    endfunction

    // floor(v / 4)
    function automatic int fdiv4(input int v);
        return (v >= 0) ? v / 4 : -((-v + 3) / 4);
    endfunction

    function automatic int sgn(input int v);
        return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        mx = 487; my = 362; mvx = 0; mvy = 0; fcnt = 0; serve = 0;
        ms1 = 0; ms2 = 0; m_goal = 0; eg1 = 0; eg2 = 0;
    endtask

    task automatic strike(input int dx, input int dy);
        mvx = clamp7(fdiv4(dx));
        mvy = clamp7(fdiv4(dy));
        if (mvx == 0 && mvy == 0) mvx = (dx >= 0) ? 1 : -1;
    endtask

    // One whole frame of puck behaviour
    task automatic model_frame();
        int dx, dy;
        bit fdue;
        eg1 = 0; eg2 = 0;
        if (m_goal) begin
            serve++;
            if (serve == 60) begin
                m_goal = 0; serve = 0; mx = 487; my = 362; fcnt = 0;
            end
            return;
        end
        fdue = (fcnt == 15);
        fcnt = fdue ? 0 : fcnt + 1;
        dx = mx - int'(xp1); dy = my - int'(yp1);
        if (dx * dx + dy * dy < 900) strike(dx, dy);
        else begin
            dx = mx - int'(xp2); dy = my - int'(yp2);
            if (dx * dx + dy * dy < 900) strike(dx, dy);
        end
        mx += mvx; my += mvy;
        if (fdue) begin mvx -= sgn(mvx); mvy -= sgn(mvy); end
        if (my >= 302 && my <= 422 && mx <= 54) begin
            eg2 = 1; ms2 = (ms2 < 15) ? ms2 + 1 : 15;
            mvx = 0; mvy = 0; m_goal = 1; serve = 0;
        end else if (my >= 302 && my <= 422 && mx >= 969) begin
            eg1 = 1; ms1 = (ms1 < 15) ? ms1 + 1 : 15;
            mvx = 0; mvy = 0; m_goal = 1; serve = 0;
        end else begin
            if (mx <= 54) begin mx = 55; mvx = iabs(mvx); end
            else if (mx >= 969) begin mx = 968; mvx = -iabs(mvx); end
            if (my <= 50) begin my = 51; mvy = iabs(mvy); end
            else if (my >= 717) begin my = 716; mvy = -iabs(mvy); end
        end
    endtask

    task automatic set_mallets(input int a, input int b, input int c, input int d);
        xp1 = 12'(a); yp1 = 12'(b); xp2 = 12'(c); yp2 = 12'(d);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".x"},    xpos_ball, mx);
        check({tag, ".y"},    ypos_ball, my);
        check({tag, ".vx"},   dut.vx, mvx);
        check({tag, ".vy"},   dut.vy, mvy);
        check({tag, ".g1"},   goal_p1, eg1);
        check({tag, ".g2"},   goal_p2, eg2);
        check({tag, ".s1"},   score_p1, ms1);
        check({tag, ".s2"},   score_p2, ms2);
        check({tag, ".busy"}, busy, m_goal);
    endtask

    // Tick in cycle T, sample just after the edge that opens cycle T+4
    task automatic run_frame(input string tag);
        @(posedge clk_in); #1 frame_tick = 1'b1;
        @(posedge clk_in); #1 frame_tick = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        model_frame();
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk_in); #1 rst = 1'b1; frame_tick = 1'b0;
        @(posedge clk_in); #1 rst = 1'b0;
        model_reset();
        check({tag, ".x"},    xpos_ball, 487);
        check({tag, ".y"},    ypos_ball, 362);
        check({tag, ".s1"},   score_p1, 0);
        check({tag, ".s2"},   score_p2, 0);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".g"},    {goal_p1, goal_p2}, 0);
        check({tag, ".vx"},   dut.vx, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int r;
        repeat (3) @(posedge clk_in);
        do_reset("rst0");

        // Mallet 1 hit: contact vector (20,0) -> vx=+5
        set_mallets(467, 362, 0, 0);
        run_frame("hit");
        check("hit.x_abs", xpos_ball, 492);
        check("hit.vx_abs", dut.vx, 5);

        // Reset mid-flight (during MOVE)
        set_mallets(0, 0, 0, 0);
        @(posedge clk_in); #1 frame_tick = 1'b1;
        @(posedge clk_in); #1 frame_tick = 1'b0;
        check("mid.busy_on", busy, 1);
        @(posedge clk_in); #1 rst = 1'b1;
        @(posedge clk_in); #1 rst = 1'b0;
        model_reset();
        check("mid.x", xpos_ball, 487);
        check("mid.y", ypos_ball, 362);
        check("mid.busy", busy, 0);

        // Friction: vx=+3 decays one step every 16 frames
        do_reset("rst1");
        set_mallets(475, 362, 0, 0);
        run_frame("fric0");
        set_mallets(0, 0, 0, 0);
        for (int i = 0; i < 47; i++) run_frame("fric");
        check("fric.x_abs", xpos_ball, 487 + 96);
        check("fric.vx_abs", dut.vx, 0);

        // Top wall bounce from a straight upward strike
        do_reset("rst2");
        set_mallets(487, 390, 0, 0);
        run_frame("wall0");
        set_mallets(0, 0, 0, 0);
        seen = 0;
        for (int i = 0; i < 150 && !seen; i++) begin
            run_frame("wall");
            if (my == 51 && mvy > 0) begin
                seen = 1;
                check("wall.y_abs", ypos_ball, 51);
                check("wall.vy_up", dut.vy > 5'sd0, 1);
            end
        end
        check("wall.seen", seen, 1);

        // Left goal: re-strike leftward every 16 frames until it scores
        do_reset("rst3");
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (i % 16 == 0) set_mallets(mx + 28, my, 0, 0);
            else set_mallets(0, 0, 0, 0);
            run_frame("goal2");
            if (eg2) seen = 1;
        end
        check("goal2.seen", seen, 1);
        check("goal2.score", score_p2, 1);
        @(posedge clk_in); #1;
        check("goal2.pulse_end", goal_p2, 0);
        set_mallets(0, 0, 0, 0);
        for (int i = 0; i < 60; i++) run_frame("serve");
        check("serve.x", xpos_ball, 487);
        check("serve.y", ypos_ball, 362);
        check("serve.vx", dut.vx, 0);
        check("serve.busy", busy, 0);

        // Right goal via mallet 2, then reset in the middle of GOAL
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (i % 16 == 0) set_mallets(0, 0, mx - 28, my);
            else set_mallets(0, 0, 0, 0);
            run_frame("goal1");
            if (eg1) seen = 1;
        end
        check("goal1.seen", seen, 1);
        check("goal1.score", score_p1, 1);
        set_mallets(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) run_frame("goalhold");
        do_reset("rst_goal");

        // Second tick two cycles after the first is dropped
        set_mallets(467, 362, 0, 0);
        @(posedge clk_in); #1 frame_tick = 1'b1;
        @(posedge clk_in); #1 frame_tick = 1'b0;
        @(posedge clk_in); #1 frame_tick = 1'b1;
        @(posedge clk_in); #1 frame_tick = 1'b0;
        @(posedge clk_in); #1;
        model_frame();
        check("space.x", xpos_ball, 492);
        check("space.busy", busy, 0);
        repeat (4) @(posedge clk_in);
        #1;
        check("space.x_hold", xpos_ball, 492);
        check("space.busy_hold", busy, 0);

        // Randomized mallet placement around the puck
        set_mallets(0, 0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 3));
            set_mallets(0, 0, 0, 0);
            if (r == 1 || r == 3)
                set_mallets(mx + int'($urandom_range(0, 56)) - 28,
                            my + int'($urandom_range(0, 56)) - 28, 0, 0);
            if (r >= 2) begin
                xp2 = 12'(mx + int'($urandom_range(0, 56)) - 28);
                yp2 = 12'(my + int'($urandom_range(0, 56)) - 28);
            end
            run_frame("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
